// File: rtl/mem_xfer_engine_if.sv
// Memory-master bus of the block-move engine: a read request with a one-cycle
// acknowledge, and a single-cycle write strobe. The engine is the master and
// the memory mux is the slave.
interface mem_xfer_engine_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              mem_read;
    logic [ADDR_W-1:0] mem_read_idx;
    logic [DATA_W-1:0] mem_read_byte;
    logic              mem_read_ack;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_write_idx;
    logic [DATA_W-1:0] mem_write_byte;

    modport master (
        output mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
        input  mem_read_byte, mem_read_ack
    );

    modport slave (
        input  mem_read, mem_read_idx, mem_write, mem_write_idx, mem_write_byte,
        output mem_read_byte, mem_read_ack
    );
endinterface

// File: rtl/mem_xfer_engine.sv
// Block-move sequencer for the CHIP-8 core: COPY, FILL and BCD_STORE.
// The core issues one command and waits for done. Bytes are handled from the
// highest offset down to offset 0; all address arithmetic wraps at 2^ADDR_W.
module mem_xfer_engine #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    mem_xfer_engine_if.master mem
);

    // BCD digit extraction assumes an 8-bit operand (0..255).
    if (DATA_W != 8) begin : g_data_w_check
        $error("mem_xfer_engine: BCD_STORE requires DATA_W == 8");
    end

    typedef enum logic [1:0] {
        MODE_COPY = 2'd0,
        MODE_FILL = 2'd1,
        MODE_BCD  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_FILL,
        S_BCD,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] cnt_ext;
    logic [DATA_W-1:0] bcd_hund, bcd_tens, bcd_ones, bcd_digit;

    assign cnt_ext = ADDR_W'(cnt_q);
    assign busy    = busy_q;
    assign done    = done_q;

    // Decimal digits of the latched operand; the counter selects hundreds first.
    always_comb begin
        bcd_hund  = value_q / DATA_W'(100);
        bcd_tens  = (value_q / DATA_W'(10)) % DATA_W'(10);
        bcd_ones  = value_q % DATA_W'(10);
        bcd_digit = bcd_ones;
        if (cnt_q == LEN_W'(2)) begin
            bcd_digit = bcd_hund;
        end else if (cnt_q == LEN_W'(1)) begin
            bcd_digit = bcd_tens;
        end
    end

    // Next-state, datapath and memory-bus decode for the current state.
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path through the case can infer a latch.
        state_d             = state_q;
        cnt_d               = cnt_q;
        src_d               = src_q;
        dst_d               = dst_q;
        value_d             = value_q;
        data_d              = data_q;
        mem.mem_read        = 1'b0;
        mem.mem_read_idx    = '0;
        mem.mem_write       = 1'b0;
        mem.mem_write_idx   = '0;
        mem.mem_write_byte  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    value_d = value;
                    cnt_d   = (mode_e'(mode) == MODE_BCD) ? LEN_W'(2) : len;
                    // The command mode lives on in the state encoding.
                    case (mode_e'(mode))
                        MODE_COPY: state_d = S_LOAD;
                        MODE_FILL: state_d = S_FILL;
                        MODE_BCD:  state_d = S_BCD;
                        default:   state_d = S_DONE;
                    endcase
                end
            end

            S_LOAD: begin
                // Request is held until the ack and dropped in the ack cycle.
                mem.mem_read     = !mem.mem_read_ack;
                mem.mem_read_idx = src_q + cnt_ext;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (mem.mem_read_ack) begin
                    data_d  = mem.mem_read_byte;
                    state_d = S_STORE;
                end
            end

            S_STORE: begin
                mem.mem_write      = !abort;
                mem.mem_write_idx  = dst_q + cnt_ext;
                mem.mem_write_byte = data_q;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = S_LOAD;
                end
            end

            S_FILL: begin
                mem.mem_write      = !abort;
                mem.mem_write_idx  = dst_q + cnt_ext;
                mem.mem_write_byte = value_q;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end

            S_BCD: begin
                // Counter 2,1,0 maps to offsets 0,1,2: hundreds land at dst.
                mem.mem_write      = !abort;
                mem.mem_write_idx  = dst_q + (ADDR_W'(2) - cnt_ext);
                mem.mem_write_byte = bcd_digit;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy covers the working states only, so it is already low in the done cycle.
        busy_d = (state_d == S_LOAD) || (state_d == S_STORE) ||
                 (state_d == S_FILL) || (state_d == S_BCD);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered status flags; reset aborts everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            value_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            value_q <= value_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Self-checking bench for mem_xfer_engine: a byte-level memory with a
// configurable ack stall, a transaction-level model of expected reads and
// writes, and a per-cycle compare process.
module tb_mem_xfer_engine;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] value;
    logic              abort;
    logic              busy;
    logic              done;

    mem_xfer_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    mem_xfer_engine #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .value (value),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    bit [7:0]    mem_arr [4096];
    bit [7:0]    ref_mem [4096];
    logic        ack_r;
    logic [7:0]  rbyte_r;
    logic        pl_we;
    logic [11:0] pl_addr;
    logic [7:0]  pl_data;
    int          cur_stall;
    int          wait_cnt;

    assign mem_if.mem_read_ack  = ack_r;
    assign mem_if.mem_read_byte = rbyte_r;

    initial begin
        ack_r    = 1'b0;
        rbyte_r  = 8'h00;
        wait_cnt = 0;
    end

    // Writes commit on the rising edge; reads are acked at mid-cycle once the
    // request has been held for cur_stall full cycles, and ack lasts to the edge.
    always @(clk) begin
        if (clk) begin
            ack_r <= 1'b0;
            if (mem_if.mem_write) mem_arr[mem_if.mem_write_idx] <= mem_if.mem_write_byte;
            if (pl_we) mem_arr[pl_addr] <= pl_data;
        end else begin
            if (mem_if.mem_read) begin
                if (wait_cnt >= cur_stall) begin
                    ack_r    <= 1'b1;
                    rbyte_r  <= mem_arr[mem_if.mem_read_idx];
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                wait_cnt <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_wr [$];
    logic [11:0] exp_rd [$];
    int n_checks = 0;
    int n_errors = 0;
    int busy_cyc = 0;
    int done_cnt = 0;
    int wr_cnt   = 0;
    int rd_run   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the expected transaction queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_if.mem_write) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("no_unexpected_write", 32'(mem_if.mem_write_idx) | 32'h8000_0000, 32'h0);
                end else begin
                    check("wr_idx",  32'(mem_if.mem_write_idx),  32'(exp_wr[0].a));
                    check("wr_data", 32'(mem_if.mem_write_byte), 32'(exp_wr[0].d));
                    void'(exp_wr.pop_front());
                end
            end
            if (mem_if.mem_read && !mem_if.mem_read_ack) rd_run++;
            if (mem_if.mem_read || mem_if.mem_read_ack) begin
                if (exp_rd.size() == 0) begin
                    check("no_unexpected_read", 32'(mem_if.mem_read_idx) | 32'h8000_0000, 32'h0);
                end else begin
                    check("rd_idx", 32'(mem_if.mem_read_idx), 32'(exp_rd[0]));
                    if (mem_if.mem_read_ack) begin
                        check("rd_held_until_ack", 32'(rd_run), 32'(cur_stall));
                        check("rd_dropped_on_ack", 32'(mem_if.mem_read), 32'h0);
                        void'(exp_rd.pop_front());
                    end
                end
                if (mem_if.mem_read_ack) rd_run = 0;
            end
            if (busy && done) check("busy_low_in_done_cycle", 32'h1, 32'h0);
            if (busy) busy_cyc++;
            if (done) done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    task automatic model_copy(input logic [11:0] s, input logic [11:0] d, input logic [7:0] l);
        wr_t w;
        logic [11:0] ra;
        for (int k = int'(l); k >= 0; k--) begin
            ra  = s + 12'(k);
            w.a = d + 12'(k);
            w.d = ref_mem[ra];
            ref_mem[w.a] = w.d;
            exp_rd.push_back(ra);
            exp_wr.push_back(w);
        end
    endtask

    task automatic model_fill(input logic [11:0] d, input logic [7:0] l, input logic [7:0] v, input int limit);
        wr_t w;
        for (int k = int'(l); k >= 0 && (int'(l) - k) < limit; k--) begin
            w.a = d + 12'(k);
            w.d = v;
            ref_mem[w.a] = v;
            exp_wr.push_back(w);
        end
    endtask

    task automatic model_bcd(input logic [11:0] d, input logic [7:0] v);
        wr_t w;
        int  digits [3];
        digits[0] = int'(v) / 100;
        digits[1] = (int'(v) / 10) % 10;
        digits[2] = int'(v) % 10;
        for (int i = 0; i < 3; i++) begin
            w.a = d + 12'(i);
            w.d = 8'(digits[i]);
            ref_mem[w.a] = w.d;
            exp_wr.push_back(w);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic [1:0] m, input logic [11:0] s, input logic [11:0] d,
                         input logic [7:0] l, input logic [7:0] v);
        mode  = m;
        src   = s;
        dst   = d;
        len   = l;
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check({name, "_done_within_budget"}, 32'(seen), 32'h1);
        tick();
    endtask

    int b0, d0, w0;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        src   = '0;
        dst   = '0;
        len   = '0;
        value = '0;
        abort = 1'b0;
        pl_we = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        cur_stall = 0;

        // Reset state.
        #1;
        check("rst_busy",      32'(busy), 32'h0);
        check("rst_done",      32'(done), 32'h0);
        check("rst_mem_read",  32'(mem_if.mem_read), 32'h0);
        check("rst_mem_write", 32'(mem_if.mem_write), 32'h0);
        check("rst_rd_idx",    32'(mem_if.mem_read_idx), 32'h0);
        check("rst_wr_idx",    32'(mem_if.mem_write_idx), 32'h0);
        check("rst_wr_byte",   32'(mem_if.mem_write_byte), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // COPY with a start pulse while busy that must be ignored.
        preload(12'h020, 8'h11);
        preload(12'h021, 8'h22);
        preload(12'h022, 8'h33);
        preload(12'h023, 8'h44);
        model_copy(12'h020, 12'h300, 8'd3);
        b0 = busy_cyc; d0 = done_cnt;
        issue(2'd0, 12'h020, 12'h300, 8'd3, 8'h00);
        tick();
        issue(2'd1, 12'h500, 12'h500, 8'd5, 8'h99);
        wait_done("copy", 50);
        check("copy_busy_cycles", 32'(busy_cyc - b0), 32'd8);
        check("copy_done_once",   32'(done_cnt - d0), 32'd1);
        repeat (5) tick();
        check("copy_no_second_done", 32'(done_cnt - d0), 32'd1);
        check("copy_mem_303", 32'(mem_arr[12'h303]), 32'h44);
        check("copy_mem_302", 32'(mem_arr[12'h302]), 32'h33);
        check("copy_mem_301", 32'(mem_arr[12'h301]), 32'h22);
        check("copy_mem_300", 32'(mem_arr[12'h300]), 32'h11);
        check("copy_no_write_at_500", 32'(mem_arr[12'h500]), 32'h00);
        check("copy_writes_drained", 32'(exp_wr.size()), 32'd0);
        check("copy_reads_drained",  32'(exp_rd.size()), 32'd0);

        // FILL of 256 bytes with zero over a region seeded at both ends.
        preload(12'h100, 8'hEE);
        preload(12'h1FF, 8'hEE);
        model_fill(12'h100, 8'hFF, 8'h00, 256);
        b0 = busy_cyc; d0 = done_cnt; w0 = wr_cnt;
        issue(2'd1, 12'h000, 12'h100, 8'hFF, 8'h00);
        wait_done("fill", 300);
        check("fill_busy_cycles", 32'(busy_cyc - b0), 32'd256);
        check("fill_write_count", 32'(wr_cnt - w0),   32'd256);
        check("fill_done_once",   32'(done_cnt - d0), 32'd1);
        check("fill_mem_100", 32'(mem_arr[12'h100]), 32'h00);
        check("fill_mem_1ff", 32'(mem_arr[12'h1FF]), 32'h00);
        check("fill_writes_drained", 32'(exp_wr.size()), 32'd0);

        // BCD_STORE of 254.
        model_bcd(12'h400, 8'hFE);
        b0 = busy_cyc; d0 = done_cnt;
        issue(2'd2, 12'h000, 12'h400, 8'h00, 8'hFE);
        wait_done("bcd", 20);
        check("bcd_busy_cycles", 32'(busy_cyc - b0), 32'd3);
        check("bcd_done_once",   32'(done_cnt - d0), 32'd1);
        check("bcd_mem_400", 32'(mem_arr[12'h400]), 32'd2);
        check("bcd_mem_401", 32'(mem_arr[12'h401]), 32'd5);
        check("bcd_mem_402", 32'(mem_arr[12'h402]), 32'd4);

        // Wrapping COPY with a 3-cycle ack stall.
        preload(12'hFFE, 8'hA1);
        preload(12'hFFF, 8'hB2);
        preload(12'h000, 8'hC3);
        cur_stall = 3;
        model_copy(12'hFFE, 12'hFFF, 8'd2);
        b0 = busy_cyc; d0 = done_cnt;
        issue(2'd0, 12'hFFE, 12'hFFF, 8'd2, 8'h00);
        wait_done("wrap", 100);
        check("wrap_busy_cycles", 32'(busy_cyc - b0), 32'd15);
        check("wrap_done_once",   32'(done_cnt - d0), 32'd1);
        check("wrap_mem_001", 32'(mem_arr[12'h001]), 32'hC3);
        check("wrap_mem_000", 32'(mem_arr[12'h000]), 32'hB2);
        check("wrap_mem_fff", 32'(mem_arr[12'hFFF]), 32'hA1);
        check("wrap_reads_drained", 32'(exp_rd.size()), 32'd0);
        cur_stall = 0;

        // Abort a 16-byte FILL in its 5th write cycle.
        model_fill(12'h200, 8'd15, 8'h5A, 4);
        d0 = done_cnt; w0 = wr_cnt;
        issue(2'd1, 12'h000, 12'h200, 8'd15, 8'h5A);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_low", 32'(busy), 32'h0);
        tick();
        tick();
        check("abort_no_done",     32'(done_cnt - d0), 32'd0);
        check("abort_write_count", 32'(wr_cnt - w0),   32'd4);
        check("abort_mem_20c", 32'(mem_arr[12'h20C]), 32'h5A);
        check("abort_mem_20b", 32'(mem_arr[12'h20B]), 32'h00);

        // A following start is accepted normally.
        model_fill(12'h210, 8'd1, 8'h77, 2);
        b0 = busy_cyc; d0 = done_cnt;
        issue(2'd1, 12'h000, 12'h210, 8'd1, 8'h77);
        wait_done("post_abort", 20);
        check("post_abort_busy_cycles", 32'(busy_cyc - b0), 32'd2);
        check("post_abort_done_once",   32'(done_cnt - d0), 32'd1);
        check("post_abort_mem_210", 32'(mem_arr[12'h210]), 32'h77);

        // Reset dropped during the first STORE of a COPY.
        preload(12'h050, 8'h61);
        preload(12'h051, 8'h62);
        exp_rd.push_back(12'h051);
        d0 = done_cnt;
        issue(2'd0, 12'h050, 12'h600, 8'd1, 8'h00);
        tick();
        check("rst_mid_pre_write", 32'(mem_if.mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_read",  32'(mem_if.mem_read),  32'h0);
        check("rst_mid_mem_write", 32'(mem_if.mem_write), 32'h0);
        check("rst_mid_busy",      32'(busy), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_mid_no_done",   32'(done_cnt - d0), 32'd0);
        check("rst_mid_write_dropped", 32'(mem_arr[12'h601]), 32'h00);
        check("rst_mid_reads_drained", 32'(exp_rd.size()), 32'd0);
        check("rst_mid_writes_drained", 32'(exp_wr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_xfer_engine.md
Name: mem_xfer_engine

Overview:
- Parametrised memory sequencer for block moves: COPY, FILL and BCD_STORE.
- Takes over the transfer, clear and BCD store sequences that the CHIP-8 core currently runs in its own state machine. The core issues one command and waits.
- Drives the same single-port memory protocol as mem: read request with ack, and single-cycle write.
- Sits between the CPU sequencer and the memory mux, in parallel with the GPU as a memory master.

Parameters:
- ADDR_W, 12, memory address width; all address arithmetic wraps modulo 2^ADDR_W.
- LEN_W, 8, width of the length field. A transfer moves len+1 bytes, max 2^LEN_W.
- DATA_W, 8, memory data width. BCD_STORE requires DATA_W == 8 (elaboration-time check).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, sampled only in IDLE
- mode  in  2  0=COPY, 1=FILL, 2=BCD_STORE, 3=reserved (treated as no-op)
- src  in  ADDR_W  COPY source base
- dst  in  ADDR_W  destination base
- len  in  LEN_W  byte count minus one (COPY/FILL); ignored for BCD_STORE
- value  in  DATA_W  FILL byte, or BCD_STORE operand
- abort  in  1  cancel the current command
- busy  out  1  high from the cycle after an accepted start until the return to IDLE
- done  out  1  one-cycle pulse on normal completion
- mem_read  out  1  read request
- mem_read_idx  out  ADDR_W  read address
- mem_read_byte  in  DATA_W  read data, valid while mem_read_ack is high
- mem_read_ack  in  1  one-cycle read acknowledge
- mem_write  out  1  write strobe (one byte per cycle)
- mem_write_idx  out  ADDR_W  write address
- mem_write_byte  out  DATA_W  write data

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, mem_read=0, mem_write=0. Index and data outputs are 0.
- Reset asserted mid-operation: immediate return to IDLE. A write in flight is dropped and no done is pulsed.
- start && IDLE:
  - latch src, dst, value and mode;
  - counter <= len (BCD_STORE: counter <= 2);
  - next state: COPY→LOAD, FILL→FILL, BCD_STORE→BCD, reserved→DONE.
- start while busy: ignored, no queueing.
- Byte order: counter counts down from len to 0. Byte at offset k is handled at src+k / dst+k, so the highest offset goes first.
- LOAD:
  - mem_read = !mem_read_ack (combinational), mem_read_idx = src+counter.
  - On mem_read_ack: capture mem_read_byte into data_reg, go to STORE.
  - Wait time is unbounded.
- STORE: mem_write=1, idx=dst+counter, byte=data_reg. If counter==0 go to DONE, else decrement and return to LOAD.
- FILL: mem_write=1 every cycle, idx=dst+counter, byte=value. Decrement each cycle; when counter==0, go to DONE after the write.
- BCD:
  - three consecutive write cycles: hundreds at dst, tens at dst+1, ones at dst+2;
  - digits are computed combinationally from the latched value (0..255);
  - hundreds is 0..2, zero-extended.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE. busy is therefore low in the done cycle.
- abort high in any non-IDLE state:
  - next edge goes to IDLE with no done;
  - no write is issued in the abort cycle (mem_write gated by !abort);
  - an outstanding read ack is discarded.
- abort in IDLE: no effect. Simultaneous start+abort in IDLE: start wins.
- Wrap-around: src+counter and dst+counter are truncated to ADDR_W. Overlapping src/dst ranges are copied byte-wise in descending order; no overlap correction.
- Throughput with a next-cycle-ack memory: COPY 2 cycles/byte, FILL 1 cycle/byte, BCD 3 cycles. The done cycle is extra.

Test Plan:
- COPY: src=0x020, dst=0x300, len=3, memory 0x020..0x023={11,22,33,44}.
  - Required: writes at 0x303,0x302,0x301,0x300 = 44,33,22,11.
  - done pulses exactly once; busy high for 8 cycles with a 1-cycle-ack memory.
- FILL: dst=0x100, len=0xFF, value=0.
  - Required: 256 consecutive write cycles covering 0x1FF down to 0x100, all data 0, then done.
- BCD_STORE: value=0xFE, dst=0x400.
  - Required: writes 0x400=2, 0x401=5, 0x402=4 on consecutive cycles, then done.
- Wrap and stall: COPY src=0xFFE, dst=0xFFF, len=2 on ADDR_W=12, with the memory stalling the ack by 3 cycles per read.
  - Required: reads 0x000, 0xFFF, 0xFFE; writes 0x001, 0x000, 0xFFF.
  - mem_read is held until each ack.
- abort during a FILL of len=15 at the 5th write cycle.
  - Required: exactly 4 writes occur, no done, busy low next cycle.
  - A following start is accepted normally.
- rst_n dropped mid-COPY.
  - Required: mem_read and mem_write low immediately, and busy=0.
  - start while busy is ignored: no second done and no extra writes.
